// File: rtl/speech_pkg.sv
// rtl/speech_pkg.sv - shared widths and input FSM state for the distance datapath
package speech_pkg;

    localparam int DW    = 16;
    localparam int NCOEF = 13;
    localparam int WW    = 4;
    localparam int ACCW  = 64;

    typedef enum logic {
        IDLE,
        ACCUM
    } state_t;

endpackage

// File: rtl/euclidean_distance_accum_if.sv
// rtl/euclidean_distance_accum_if.sv - coefficient input stream and distance result signals
interface euclidean_distance_accum_if #(
    parameter int DW   = speech_pkg::DW,
    parameter int WW   = speech_pkg::WW,
    parameter int ACCW = speech_pkg::ACCW
);

    logic            ivalid;
    logic [WW-1:0]   iword;
    logic [DW-1:0]   ifeat;
    logic [DW-1:0]   itmpl;
    logic            ovalid;
    logic [WW-1:0]   oword;
    logic [ACCW-1:0] odata;
    logic            obusy;
    logic            oerr;

    modport slave (
        input  ivalid, iword, ifeat, itmpl,
        output ovalid, oword, odata, obusy, oerr
    );

    modport master (
        output ivalid, iword, ifeat, itmpl,
        input  ovalid, oword, odata, obusy, oerr
    );

endinterface

// File: rtl/sq_diff.sv
// rtl/sq_diff.sv - two registered stages: signed difference, then its square, with tags alongside
module sq_diff #(
    parameter int DW = speech_pkg::DW,
    parameter int TW = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    input  logic signed [DW-1:0]  in_feat,
    input  logic signed [DW-1:0]  in_tmpl,
    input  logic [TW-1:0]         in_tag,
    output logic                  s1_vld,
    output logic                  s2_vld,
    output logic [TW-1:0]         s2_tag,
    output logic [2*DW+1:0]       s2_sq
);

    logic signed [DW:0]     s1_diff;
    logic [TW-1:0]          s1_tag;
    logic signed [2*DW+1:0] prod;

    // The square of a (DW+1)-bit signed value is never negative, so the raw bits are the unsigned result.
    assign prod = (2*DW+2)'(s1_diff) * (2*DW+2)'(s1_diff);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_diff <= '0;
            s1_tag  <= '0;
            s2_vld  <= 1'b0;
            s2_sq   <= '0;
            s2_tag  <= '0;
        end else begin
            s1_vld  <= in_vld;
            s1_diff <= (DW+1)'(in_feat) - (DW+1)'(in_tmpl);
            s1_tag  <= in_tag;
            s2_vld  <= s1_vld;
            s2_sq   <= unsigned'(prod);
            s2_tag  <= s1_tag;
        end
    end

endmodule

// File: rtl/euclidean_distance_accum.sv
// rtl/euclidean_distance_accum.sv - accumulates squared coefficient differences into one distance per template vector
module euclidean_distance_accum #(
    parameter int DW    = speech_pkg::DW,
    parameter int NCOEF = speech_pkg::NCOEF,
    parameter int WW    = speech_pkg::WW,
    parameter int ACCW  = speech_pkg::ACCW
) (
    input  logic                      iclk,
    input  logic                      irst,
    euclidean_distance_accum_if.slave bus
);

    import speech_pkg::*;

    localparam int CW  = $clog2(NCOEF);
    localparam int TW  = WW + 3;
    localparam int SQW = 2 * (DW + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   word_q, word_d;
    logic            take, first, last, mis;

    logic            s1_vld, s2_vld;
    logic [TW-1:0]   s2_tag;
    logic [SQW-1:0]  s2_sq;
    logic            s2_first, s2_last, s2_abort;
    logic [WW-1:0]   s2_word;

    logic [ACCW-1:0] acc_q, acc_next;
    logic            s3_vld, s3_last;
    logic [WW-1:0]   s3_word;
    logic            ovalid_q, oerr_q;
    logic [WW-1:0]   oword_q;
    logic [ACCW-1:0] odata_q;

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // A word change inside a vector takes priority over the LAST position.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        take    = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        mis     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.ivalid) begin
                    take    = 1'b1;
                    first   = 1'b1;
                    word_d  = bus.iword;
                    cnt_d   = CW'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.ivalid) begin
                    if (bus.iword != word_q) begin
                        mis     = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        take = 1'b1;
                        if (cnt_q == CW'(NCOEF - 1)) begin
                            last    = 1'b1;
                            cnt_d   = '0;
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // The abort marker rides in the dropped sample's slot, behind every sample of the dead vector.
    sq_diff #(
        .DW (DW),
        .TW (TW)
    ) u_sq_diff (
        .clk     (iclk),
        .rst     (irst),
        .in_vld  (take),
        .in_feat (bus.ifeat),
        .in_tmpl (bus.itmpl),
        .in_tag  ({bus.iword, mis, last & take, first & take}),
        .s1_vld  (s1_vld),
        .s2_vld  (s2_vld),
        .s2_tag  (s2_tag),
        .s2_sq   (s2_sq)
    );

    assign s2_first = s2_tag[0];
    assign s2_last  = s2_tag[1];
    assign s2_abort = s2_tag[2];
    assign s2_word  = s2_tag[TW-1:3];

    assign acc_next = (s2_first ? '0 : acc_q) + ACCW'(s2_sq);

    always_ff @(posedge iclk) begin
        if (irst) begin
            acc_q    <= '0;
            s3_vld   <= 1'b0;
            s3_last  <= 1'b0;
            s3_word  <= '0;
            ovalid_q <= 1'b0;
            oword_q  <= '0;
            odata_q  <= '0;
            oerr_q   <= 1'b0;
        end else begin
            if (s2_abort) begin
                acc_q <= '0;
            end else if (s2_vld) begin
                acc_q <= acc_next;
            end
            s3_vld   <= s2_vld;
            s3_last  <= s2_vld & s2_last;
            s3_word  <= s2_word;
            ovalid_q <= s3_vld & s3_last;
            if (s3_vld && s3_last) begin
                oword_q <= s3_word;
                odata_q <= acc_q;
            end
            oerr_q   <= mis;
        end
    end

    assign bus.ovalid = ovalid_q;
    assign bus.oword  = oword_q;
    assign bus.odata  = odata_q;
    assign bus.oerr   = oerr_q;
    assign bus.obusy  = (cnt_q != '0) || s1_vld || s2_vld || s3_vld;

endmodule

// File: tb/tb_euclidean_distance_accum.sv
// tb/tb_euclidean_distance_accum.sv - randomized and directed checks against a sum-of-squares model
module tb_euclidean_distance_accum;

    import speech_pkg::*;

    typedef struct {
        logic [WW-1:0]   word;
        longint unsigned data;
        int              edge_n;
    } exp_t;

    logic iclk = 1'b0;
    logic irst;

    always #5 iclk = ~iclk;

    euclidean_distance_accum_if bus();

    euclidean_distance_accum dut (
        .iclk (iclk),
        .irst (irst),
        .bus  (bus.slave)
    );

    exp_t                  expq[$];
    exp_t                  e_cur;
    int                    ov_edges[$];
    int                    n_tests = 0;
    int                    n_fail  = 0;
    int                    n_oerr  = 0;
    int                    ecount  = 0;
    logic signed [DW-1:0]  feat_a[NCOEF];
    logic signed [DW-1:0]  tmpl_a[NCOEF];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge iclk) ecount <= ecount + 1;

    always @(negedge iclk) begin
        if (bus.oerr === 1'b1) n_oerr++;
        if (bus.ovalid === 1'b1) begin
            ov_edges.push_back(ecount);
            if (expq.size() == 0) begin
                check("unexpected_ovalid", 64'd1, 64'd0);
            end else begin
                e_cur = expq.pop_front();
                check("odata", bus.odata, e_cur.data);
                check("oword", 64'(bus.oword), 64'(e_cur.word));
                check("latency", 64'(ecount - e_cur.edge_n), 64'd3);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic fill_const(input int f, input int t);
        for (int i = 0; i < NCOEF; i++) begin
            feat_a[i] = DW'(f);
            tmpl_a[i] = DW'(t);
        end
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NCOEF; i++) begin
            feat_a[i] = DW'($urandom);
            tmpl_a[i] = DW'($urandom);
        end
    endtask

    // gap: 0 none, 1 one idle cycle between samples, 2 random 0..2 idle cycles
    task automatic send_vec(input logic [WW-1:0] w, input int gap, input bit chk_busy,
                            input int bad_at, input logic [WW-1:0] bad_w);
        longint unsigned sum;
        longint          d;
        int              g;
        sum = 0;
        for (int i = 0; i < NCOEF; i++) begin
            d   = longint'(feat_a[i]) - longint'(tmpl_a[i]);
            sum = sum + longint'(d * d);
        end
        for (int i = 0; i < NCOEF; i++) begin
            g = 0;
            if (i > 0) g = (gap == 1) ? 1 : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (g) begin
                if (chk_busy) check("obusy_gap", 64'(bus.obusy), 64'd1);
                tick();
            end
            bus.ivalid = 1'b1;
            bus.ifeat  = feat_a[i];
            bus.itmpl  = tmpl_a[i];
            bus.iword  = (i == bad_at) ? bad_w : w;
            tick();
            bus.ivalid = 1'b0;
            if (i == bad_at) begin
                check("oerr_pulse", 64'(bus.oerr), 64'd1);
                return;
            end
            if (chk_busy && i < NCOEF - 1) check("obusy_mid", 64'(bus.obusy), 64'd1);
        end
        expq.push_back('{word: w, data: sum, edge_n: ecount});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ovalid"}, 64'(bus.ovalid), 64'd0);
        check({tag, "_oword"},  64'(bus.oword),  64'd0);
        check({tag, "_odata"},  bus.odata,       64'd0);
        check({tag, "_obusy"},  64'(bus.obusy),  64'd0);
        check({tag, "_oerr"},   64'(bus.oerr),   64'd0);
    endtask

    initial begin
        irst       = 1'b1;
        bus.ivalid = 1'b0;
        bus.iword  = '0;
        bus.ifeat  = '0;
        bus.itmpl  = '0;
        repeat (3) tick();
        check_all_zero("reset");
        irst = 1'b0;
        tick();

        fill_const(3, 1);
        send_vec(4'd2, 0, 1'b0, -1, 4'd0);
        repeat (6) tick();

        fill_const(-32768, 32767);
        send_vec(4'd5, 0, 1'b0, -1, 4'd0);
        repeat (6) tick();

        fill_const(10, 9);
        send_vec(4'd1, 0, 1'b0, -1, 4'd0);
        fill_const(-7, -5);
        send_vec(4'd2, 0, 1'b0, -1, 4'd0);
        repeat (6) tick();
        if (ov_edges.size() >= 2)
            check("b2b_spacing", 64'(ov_edges[ov_edges.size()-1] - ov_edges[ov_edges.size()-2]), 64'(NCOEF));
        else
            check("b2b_count", 64'(ov_edges.size()), 64'd2);

        fill_const(3, 1);
        send_vec(4'd2, 1, 1'b1, -1, 4'd0);
        repeat (6) tick();

        fill_const(5, 2);
        send_vec(4'd3, 0, 1'b0, 5, 4'd4);
        tick();
        check("oerr_one_cycle", 64'(bus.oerr), 64'd0);
        repeat (3) tick();
        check("obusy_after_abort", 64'(bus.obusy), 64'd0);
        fill_const(1, 0);
        send_vec(4'd4, 0, 1'b0, -1, 4'd0);
        repeat (6) tick();

        for (int i = 0; i < 7; i++) begin
            bus.ivalid = 1'b1;
            bus.iword  = 4'd9;
            bus.ifeat  = DW'(100 + i);
            bus.itmpl  = DW'(i);
            tick();
        end
        bus.ivalid = 1'b0;
        irst       = 1'b1;
        tick();
        check_all_zero("midreset");
        irst = 1'b0;
        repeat (5) tick();
        fill_const(-1, 1);
        send_vec(4'd9, 0, 1'b0, -1, 4'd0);
        repeat (6) tick();

        for (int v = 0; v < 20; v++) begin
            fill_rand();
            send_vec(WW'($urandom), int'($urandom_range(0, 2)), 1'b0, -1, 4'd0);
            if ($urandom_range(0, 1) == 1) repeat (int'($urandom_range(0, 5))) tick();
        end
        repeat (8) tick();

        check("pending_results", 64'(expq.size()), 64'd0);
        check("oerr_total", 64'(n_oerr), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
